// File: rtl/qam_measurement_sequencer_if.sv
// Control, capture-input and result handshake bundle for the QAM measurement sequencer.
interface qam_measurement_sequencer_if #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned OUT_W = 18
);
  logic             start;
  logic             continuous;
  logic             abort;
  logic             busy;
  logic [ACC_W-1:0] acc_error;
  logic [ACC_W-1:0] acc_sq_error;
  logic [ACC_W-1:0] acc_power;
  logic             result_valid;
  logic             result_ack;
  logic [OUT_W-1:0] mean_error;
  logic [OUT_W-1:0] mean_sq_error;
  logic [OUT_W-1:0] mean_power;
  logic             overrun;

  modport master (
    output start, continuous, abort, acc_error, acc_sq_error, acc_power, result_ack,
    input  busy, result_valid, mean_error, mean_sq_error, mean_power, overrun
  );

  modport slave (
    input  start, continuous, abort, acc_error, acc_sq_error, acc_power, result_ack,
    output busy, result_valid, mean_error, mean_sq_error, mean_power, overrun
  );
endinterface

// File: rtl/qam_measurement_sequencer.sv
// Clock-enable generator and flush/accumulate/capture sequencer for one I or Q rail;
// latches saturated accumulator means and hands them off via valid/ack.
module qam_measurement_sequencer #(
  parameter int unsigned MSAMPLES   = 1048576,
  parameter int unsigned SHIFT_VAL  = 20,
  parameter int unsigned FLUSH_SYMS = 8,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned OUT_W      = 18
) (
  input  logic sys_clk,
  input  logic reset_n,
  output logic sam_clk_ena,
  output logic sym_clk_ena,
  output logic clear_accumulator,
  qam_measurement_sequencer_if.slave ctl
);

  localparam int unsigned CNT_MAX = (MSAMPLES > FLUSH_SYMS) ? MSAMPLES : FLUSH_SYMS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FLUSH   = 3'd1;
  localparam logic [2:0] ACCUM   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RELOAD  = 3'd4;

  logic [3:0]       clk_phase;
  logic [2:0]       state;
  logic [CNT_W-1:0] sym_cnt;
  logic             cont_mode;

  logic signed [ACC_W-1:0] err_shr;
  logic [ACC_W-1:0]        sq_shr;
  logic [ACC_W-1:0]        pwr_shr;
  logic [OUT_W-1:0]        err_sat;
  logic [OUT_W-1:0]        sq_sat;
  logic [OUT_W-1:0]        pwr_sat;

  assign sam_clk_ena       = (clk_phase[1:0] == 2'b11);
  assign sym_clk_ena       = (clk_phase == 4'hf);
  assign clear_accumulator = (state != ACCUM);
  assign ctl.busy          = (state != IDLE);

  assign err_shr = $signed(ctl.acc_error) >>> SHIFT_VAL;
  assign sq_shr  = ctl.acc_sq_error >> SHIFT_VAL;
  assign pwr_shr = ctl.acc_power >> SHIFT_VAL;

  function automatic logic [OUT_W-1:0] sat_u(input logic [ACC_W-1:0] v);
    return (|v[ACC_W-1:OUT_W]) ? '1 : v[OUT_W-1:0];
  endfunction

  // In range only when every bit above the output sign bit matches it.
  always_comb begin
    err_sat = err_shr[OUT_W-1:0];
    if (!((&err_shr[ACC_W-1:OUT_W-1]) || !(|err_shr[ACC_W-1:OUT_W-1])))
      err_sat = {err_shr[ACC_W-1], {(OUT_W-1){~err_shr[ACC_W-1]}}};
    sq_sat  = sat_u(sq_shr);
    pwr_sat = sat_u(pwr_shr);
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      clk_phase         <= '0;
      state             <= IDLE;
      sym_cnt           <= '0;
      cont_mode         <= 1'b0;
      ctl.result_valid  <= 1'b0;
      ctl.overrun       <= 1'b0;
      ctl.mean_error    <= '0;
      ctl.mean_sq_error <= '0;
      ctl.mean_power    <= '0;
    end else begin
      clk_phase <= clk_phase + 4'd1;
      // Ack clears valid here; a capture in the same cycle overrides it below.
      if (ctl.result_valid && ctl.result_ack)
        ctl.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ctl.start) begin
            cont_mode   <= ctl.continuous;
            sym_cnt     <= '0;
            ctl.overrun <= 1'b0;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          if (ctl.abort) begin
            state <= IDLE;
          end else if (sym_clk_ena) begin
            if (sym_cnt == CNT_W'(FLUSH_SYMS - 1)) begin
              sym_cnt <= '0;
              state   <= ACCUM;
            end else begin
              sym_cnt <= sym_cnt + CNT_W'(1);
            end
          end
        end
        ACCUM: begin
          if (ctl.abort) begin
            state <= IDLE;
          end else if (sym_clk_ena) begin
            if (sym_cnt == CNT_W'(MSAMPLES - 1))
              state <= CAPTURE;
            else
              sym_cnt <= sym_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (ctl.abort) begin
            state <= IDLE;
          end else begin
            ctl.mean_error    <= err_sat;
            ctl.mean_sq_error <= sq_sat;
            ctl.mean_power    <= pwr_sat;
            ctl.result_valid  <= 1'b1;
            if (ctl.result_valid && !ctl.result_ack)
              ctl.overrun <= 1'b1;
            state <= cont_mode ? RELOAD : IDLE;
          end
        end
        RELOAD: begin
          if (ctl.abort) begin
            state <= IDLE;
          end else if (sym_clk_ena) begin
            sym_cnt <= '0;
            state   <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qam_measurement_sequencer.sv
// Directed-plus-random bench for qam_measurement_sequencer; expectations come from a
// cycle-count timing model and floor-division arithmetic for the means.
module tb_qam_measurement_sequencer;
  localparam int unsigned M  = 16;
  localparam int unsigned SH = 4;
  localparam int unsigned F  = 2;
  localparam int unsigned AW = 40;
  localparam int unsigned OW = 18;
  localparam longint DIV     = longint'(1) << SH;
  localparam longint ERR_MAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint ERR_MIN = -(longint'(1) << (OW - 1));
  localparam longint U_MAX   = (longint'(1) << OW) - 1;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  logic sam_clk_ena, sym_clk_ena, clear_accumulator;

  qam_measurement_sequencer_if #(.ACC_W(AW), .OUT_W(OW)) ctl ();

  qam_measurement_sequencer #(
    .MSAMPLES(M), .SHIFT_VAL(SH), .FLUSH_SYMS(F), .ACC_W(AW), .OUT_W(OW)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .sam_clk_ena(sam_clk_ena),
    .sym_clk_ena(sym_clk_ena),
    .clear_accumulator(clear_accumulator),
    .ctl(ctl)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int acc_lo = 1, acc_hi = 0, acc_lo2 = 1, acc_hi2 = 0;
  int busy_lo = 1, busy_hi = 0;
  int cap = 0, cap2 = 0, sf = 0;
  int low_strobes = 0;
  longint e_val, sq_val, pw_val;
  longint exp_err = 0, exp_sq = 0, exp_pw = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic longint ref_err(input longint v);
    longint q;
    q = v / DIV;
    if (v < 0 && (v % DIV) != 0) q = q - 1;
    if (q > ERR_MAX) q = ERR_MAX;
    if (q < ERR_MIN) q = ERR_MIN;
    return q;
  endfunction

  function automatic longint ref_u(input longint v);
    longint q;
    q = v / DIV;
    if (q > U_MAX) q = U_MAX;
    return q;
  endfunction

  task automatic set_acc(input longint e, input longint sq, input longint pw);
    e_val = e; sq_val = sq; pw_val = pw;
    ctl.acc_error    = e[AW-1:0];
    ctl.acc_sq_error = sq[AW-1:0];
    ctl.acc_power    = pw[AW-1:0];
  endtask

  task automatic rand_acc();
    logic [63:0] r1, r2, r3;
    longint e;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    r3 = {$urandom, $urandom};
    e  = $signed(r1) >>> $urandom_range(24, 45);
    set_acc(e, longint'(r2 >> $urandom_range(24, 50)), longint'(r3 >> $urandom_range(24, 50)));
  endtask

  task automatic capture_model();
    exp_err = ref_err(e_val);
    exp_sq  = ref_u(sq_val);
    exp_pw  = ref_u(pw_val);
  endtask

  task automatic check_means(input string tag);
    chk({tag, ".mean_error"}, 64'($signed(ctl.mean_error)), 64'(exp_err));
    chk({tag, ".mean_sq_error"}, 64'(ctl.mean_sq_error), 64'(exp_sq));
    chk({tag, ".mean_power"}, 64'(ctl.mean_power), 64'(exp_pw));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".sam"}, sam_clk_ena, 1'b0);
    chk({tag, ".sym"}, sym_clk_ena, 1'b0);
    chk({tag, ".clear"}, clear_accumulator, 1'b1);
    chk({tag, ".busy"}, ctl.busy, 1'b0);
    chk({tag, ".valid"}, ctl.result_valid, 1'b0);
    chk({tag, ".overrun"}, ctl.overrun, 1'b0);
    check_means(tag);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    n++;
  endtask

  task automatic run_until(input int target);
    logic in_acc, exp_busy;
    while (n < target) begin
      tick();
      in_acc   = (n >= acc_lo && n <= acc_hi) || (n >= acc_lo2 && n <= acc_hi2);
      exp_busy = (n >= busy_lo && n <= busy_hi);
      chk("sam_clk_ena", sam_clk_ena, (n % 4 == 3));
      chk("sym_clk_ena", sym_clk_ena, (n % 16 == 15));
      chk("clear_accumulator", clear_accumulator, !in_acc);
      chk("busy", ctl.busy, exp_busy);
      if (sym_clk_ena && !clear_accumulator) low_strobes++;
    end
  endtask

  // Predict window timing for a start that is sampled at the next edge.
  task automatic plan(input bit cont);
    int ns, s1;
    ns      = n + 1;
    s1      = ns + ((15 - (ns % 16)) + 16) % 16;
    sf      = s1 + 16 * (F - 1);
    acc_lo  = sf + 1;
    cap     = sf + 16 * M + 1;
    acc_hi  = cap - 1;
    busy_lo = ns;
    busy_hi = cont ? cap + 16 * 40 : cap;
    if (cont) begin
      acc_lo2 = cap + 16;
      cap2    = cap + 16 * (M + 1);
      acc_hi2 = cap2 - 1;
    end else begin
      acc_lo2 = 1;
      acc_hi2 = 0;
    end
    low_strobes = 0;
  endtask

  task automatic do_start(input bit cont, input bit with_abort);
    ctl.continuous = cont;
    ctl.start      = 1'b1;
    ctl.abort      = with_abort;
    plan(cont);
    run_until(n + 1);
    ctl.start      = 1'b0;
    ctl.abort      = 1'b0;
    ctl.continuous = 1'b0;
  endtask

  task automatic ack_pulse();
    ctl.result_ack = 1'b1;
    run_until(n + 1);
    ctl.result_ack = 1'b0;
  endtask

  initial begin
    ctl.start = 1'b0; ctl.continuous = 1'b0; ctl.abort = 1'b0; ctl.result_ack = 1'b0;
    set_acc(0, 0, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    check_reset("reset");

    // Free-running enables while idle
    run_until(64);

    // Single shot with fixed accumulator values
    set_acc(-320, 1600, 4096);
    do_start(1'b0, 1'b0);
    run_until(cap);
    chk("t2.valid_before_capture", ctl.result_valid, 1'b0);
    run_until(cap + 1);
    capture_model();
    chk("t2.accum_strobes", 64'(low_strobes), 64'(M));
    chk("t2.valid", ctl.result_valid, 1'b1);
    chk("t2.mean_error_const", 64'($signed(ctl.mean_error)), 64'(-20));
    chk("t2.mean_sq_const", 64'(ctl.mean_sq_error), 64'(100));
    chk("t2.mean_power_const", 64'(ctl.mean_power), 64'(256));
    check_means("t2");
    chk("t2.overrun", ctl.overrun, 1'b0);
    ack_pulse();
    chk("t2.valid_after_ack", ctl.result_valid, 1'b0);
    check_means("t2.hold");

    // Continuous, no ack: reload drops one symbol, second capture overruns
    rand_acc();
    do_start(1'b1, 1'b0);
    run_until(cap + 1);
    capture_model();
    chk("t3.valid1", ctl.result_valid, 1'b1);
    chk("t3.overrun1", ctl.overrun, 1'b0);
    check_means("t3.cap1");
    rand_acc();
    low_strobes = 0;
    run_until(cap2 + 1);
    capture_model();
    chk("t3.accum_strobes2", 64'(low_strobes), 64'(M));
    chk("t3.valid2", ctl.result_valid, 1'b1);
    chk("t3.overrun2", ctl.overrun, 1'b1);
    check_means("t3.cap2");
    busy_hi = cap2 + 1;
    acc_hi2 = cap2 - 1;
    ctl.abort = 1'b1;
    run_until(n + 1);
    ctl.abort = 1'b0;
    chk("t3.abort_valid", ctl.result_valid, 1'b1);
    chk("t3.abort_overrun", ctl.overrun, 1'b1);
    check_means("t3.abort");

    // Start clears overrun; saturating capture
    set_acc(-(longint'(1) << 30), longint'(1) << 30, 64'd12345);
    do_start(1'b0, 1'b0);
    chk("t4.overrun_cleared", ctl.overrun, 1'b0);
    chk("t4.valid_kept", ctl.result_valid, 1'b1);
    ack_pulse();
    chk("t4.valid_acked", ctl.result_valid, 1'b0);
    run_until(cap + 1);
    capture_model();
    chk("t4.sat_sq", 64'(ctl.mean_sq_error), 64'(262143));
    chk("t4.sat_err", 64'($signed(ctl.mean_error)), 64'(-131072));
    check_means("t4");
    chk("t4.valid", ctl.result_valid, 1'b1);
    chk("t4.overrun", ctl.overrun, 1'b0);

    // Abort at the 7th accumulate strobe with a result pending
    rand_acc();
    do_start(1'b0, 1'b0);
    acc_hi  = sf + 16 * 7;
    busy_hi = sf + 16 * 7;
    run_until(sf + 16 * 7);
    ctl.abort = 1'b1;
    run_until(n + 1);
    ctl.abort = 1'b0;
    chk("t5.clear", clear_accumulator, 1'b1);
    chk("t5.busy", ctl.busy, 1'b0);
    chk("t5.valid", ctl.result_valid, 1'b1);
    chk("t5.overrun", ctl.overrun, 1'b0);
    check_means("t5.unchanged");

    // Reset mid-accumulate
    rand_acc();
    do_start(1'b0, 1'b0);
    run_until(acc_lo + int'($urandom_range(0, 100)));
    reset_n = 1'b0;
    @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    acc_lo = 1; acc_hi = 0; acc_lo2 = 1; acc_hi2 = 0; busy_lo = 1; busy_hi = 0;
    exp_err = 0; exp_sq = 0; exp_pw = 0;
    check_reset("t6.reset");

    // Start and abort together in idle; then ack coinciding with capture
    run_until(int'($urandom_range(1, 20)));
    rand_acc();
    do_start(1'b0, 1'b1);
    run_until(cap + 1);
    capture_model();
    chk("t6.valid_a", ctl.result_valid, 1'b1);
    check_means("t6.a");
    rand_acc();
    do_start(1'b0, 1'b0);
    run_until(cap);
    ctl.result_ack = 1'b1;
    run_until(cap + 1);
    ctl.result_ack = 1'b0;
    capture_model();
    chk("t6.coincident_valid", ctl.result_valid, 1'b1);
    chk("t6.coincident_overrun", ctl.overrun, 1'b0);
    check_means("t6.b");
    ack_pulse();
    chk("t6.valid_acked", ctl.result_valid, 1'b0);
    ack_pulse();
    chk("t6.stray_ack_valid", ctl.result_valid, 1'b0);
    chk("t6.stray_ack_overrun", ctl.overrun, 1'b0);

    // Random single-shot windows
    for (int i = 0; i < 3; i++) begin
      rand_acc();
      do_start(1'b0, 1'b0);
      run_until(cap + 1);
      capture_model();
      chk("rnd.valid", ctl.result_valid, 1'b1);
      chk("rnd.overrun", ctl.overrun, 1'b0);
      check_means("rnd");
      ack_pulse();
      chk("rnd.valid_acked", ctl.result_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qam_measurement_sequencer.md
Name: qam_measurement_sequencer

Overview:
- Timing and measurement controller for one I or Q rail of the 16QAM receiver test path.
- Generates the sample and symbol clock enables from the system clock.
- Sequences flush, accumulate and capture windows of MSAMPLES symbols by driving clear_accumulator into the reference-level and error accumulators.
- Latches the scaled averages and hands them to a reader through a valid/ack handshake.

Parameters:
- MSAMPLES, 1048576: symbols per measurement window; must be ≥2.
- SHIFT_VAL, 20: arithmetic right shift applied to accumulator values; log2(MSAMPLES).
- FLUSH_SYMS, 8: symbols discarded after start, while the pipeline fills, before accumulation begins; must be ≥1.
- ACC_W, 40: width of accumulator inputs.
- OUT_W, 18: width of the mean outputs.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a measurement.
- continuous  in  1  sampled at start; 1 = back-to-back windows, 0 = single shot.
- abort  in  1  cancel any measurement in progress.
- sam_clk_ena  out  1  sample enable, 1 of every 4 cycles.
- sym_clk_ena  out  1  symbol enable, 1 of every 16 cycles.
- clear_accumulator  out  1  holds or clears the downstream accumulators.
- busy  out  1  high when state ≠ IDLE.
- acc_error  in  ACC_W  signed accumulated error.
- acc_sq_error  in  ACC_W  unsigned accumulated squared error.
- acc_power  in  ACC_W  unsigned accumulated mapper output power.
- result_valid  out  1  captured results available.
- result_ack  in  1  reader consumes the results.
- mean_error  out  OUT_W  signed mean error.
- mean_sq_error  out  OUT_W  unsigned mean squared error.
- mean_power  out  OUT_W  unsigned mean power.
- overrun  out  1  sticky flag: a result was overwritten before it was acknowledged.

Behaviour:
- Reset values: clk_phase=0, state=IDLE, sym_cnt=0, all means 0, result_valid=0, overrun=0, busy=0, clear_accumulator=1, both enables 0.
- Phase counter:
  - 4-bit clk_phase increments every cycle and wraps 15→0.
  - It runs in every state and is not affected by abort.
  - Both enables are decoded combinationally from clk_phase.
  - sam_clk_ena=1 when clk_phase ∈ {3,7,11,15}.
  - sym_clk_ena=1 when clk_phase=15.
  - First symbol strobe is the 16th cycle after reset release.
- State machine:
  - IDLE: clear_accumulator=1. On start: latch continuous, set sym_cnt=0, go to FLUSH. start in any other state is ignored.
  - FLUSH: clear_accumulator=1. Count symbol strobes. On the FLUSH_SYMS-th strobe go to ACCUM with sym_cnt=0.
  - ACCUM: clear_accumulator=0. Count symbol strobes. On the MSAMPLES-th strobe go to CAPTURE.
  - CAPTURE: lasts one cycle, sampling the accumulator inputs one cycle after the final strobe (the accumulators register on that strobe). Update the means and set result_valid=1. If result_valid was already 1 and result_ack is not asserted this cycle, set overrun=1. clear_accumulator=1. Next state is RELOAD if continuous was latched, otherwise IDLE.
  - RELOAD: clear_accumulator=1 up to and including the next symbol strobe, which clears the accumulators and discards that symbol. Then go to ACCUM with sym_cnt=0. No flush is repeated.
- Mean arithmetic:
  - Each output is the accumulator value shifted right by SHIFT_VAL: arithmetic shift for acc_error, logical shift for the other two.
  - mean_error saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - mean_sq_error and mean_power saturate to 2^OUT_W−1.
- Handshake:
  - result_valid stays high until result_ack is seen while result_valid=1; it clears on the next cycle.
  - result_ack while result_valid=0 is ignored.
  - If result_ack and CAPTURE occur in the same cycle, the capture wins: result_valid stays 1 and overrun is not set.
  - The mean outputs hold their values until the next CAPTURE.
- Sticky flag and abort:
  - overrun clears only on reset or on an accepted start.
  - abort in any non-IDLE state goes to IDLE on the next cycle and discards the partial window.
  - abort leaves the means, result_valid and overrun untouched.
  - If abort and start occur in the same cycle while in IDLE, start is accepted.
- Reset while a measurement is in progress restores all reset values on the next cycle.
- sym_cnt width is $clog2(MSAMPLES+1); it must not wrap inside a window.

Test Plan:
1. Release reset and run 64 cycles → sam_clk_ena high at cycles 3,7,11,15,…; sym_clk_ena high at 15,31,47,63; clear_accumulator=1; busy=0.
2. MSAMPLES=16, SHIFT_VAL=4, FLUSH_SYMS=2. Single-shot start; acc_error=−320, acc_sq_error=1600, acc_power=4096 → clear_accumulator low for exactly 16 strobes; result_valid rises 1 cycle after the 18th strobe; means = −20, 100, 256; next state IDLE; busy=0.
3. Same parameters with continuous=1 and no ack → RELOAD drops one symbol; second capture 17 strobes after the first; overrun=1; means updated. Then a start from IDLE clears overrun.
4. Saturation: acc_sq_error=2^30, acc_error=−2^30, SHIFT_VAL=4 → mean_sq_error=262143, mean_error=−131072.
5. abort asserted at the 7th ACCUM strobe with a prior result pending → IDLE next cycle; clear_accumulator=1; result_valid=1 and the means are unchanged.
6. reset_n low for 1 cycle during ACCUM; also result_ack coinciding with CAPTURE → all outputs at reset values; in the coincident case result_valid=1 and overrun=0.
